sprite_anim_sched: RTL and testbench
====================================

Name: sprite_anim_sched

Overview:
- Shares one 3-bank sprite frame ROM (frames F0/F1/F2, one synchronous read port each, common address) among NREQ pixel requesters from the VGA pixel pipeline.
- Generates the animation step sequence from the free-running pixel clock.
- Arbitrates ROM access round-robin and returns 12-bit RGB pixels tagged with requester id.
- Applies the per-requester "hit" flash-colour override.
- Sits between the VGA scan/coordinate logic and the frame ROMs; replaces per-sprite frame muxing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 12, ROM address width.
- PIX_W, 12, pixel width (4:4:4 RGB).
- TICK_DIV, 6000000, clk cycles per animation step (>=2).
- HIT_COLOR, 12'h428, override colour when hit asserted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pause  in  1  freeze tick counter and step counter.
- req  in  NREQ  per-requester read request, level; held until granted.
- req_addr  in  NREQ*ADDR_W  per-requester address, slice i = [i*ADDR_W +: ADDR_W]; stable while req[i]=1.
- hit  in  NREQ  per-requester flash override.
- grant  out  NREQ  one-hot, 1-cycle pulse when request accepted.
- rom_addr  out  ADDR_W  shared address to all three frame ROMs.
- rom_d0 / rom_d1 / rom_d2  in  PIX_W each  ROM outputs, valid 1 cycle after rom_addr.
- pix_valid  out  1  pixel output valid.
- pix_id  out  log2(NREQ) (min 1)  requester owning pix_data.
- pix_data  out  PIX_W  returned pixel.
- step  out  4  current animation step.

Behaviour:
- Async reset values: tick_cnt=0, step=0, rr_ptr=0, grant=0, rom_addr=0, pix_valid=0, pix_id=0, pix_data=0, pipeline valids=0.
- Tick: tick_cnt counts 0..TICK_DIV-1 when pause=0; tick=1 in the cycle tick_cnt==TICK_DIV-1, then tick_cnt wraps to 0.
- Step: step increments by 1 on tick, 4-bit wrap 15->0.
- pause=1 holds tick_cnt and step; arbitration continues.
- Frame select from step:
  - 0-3 -> F0
  - 4-7 -> F1
  - 8-11 -> F2
  - 12-15 -> F0
- Arbiter, cycle A:
  - If any req, grant the first requesting index at or after rr_ptr (wrapping).
  - Set rr_ptr = granted+1 mod NREQ.
  - Drive grant pulse and register rom_addr=req_addr[g].
  - Latch into stage-1: id=g, fsel (from the step value in cycle A), hit[g] sampled in cycle A, v1=1.
  - At most one grant per cycle; a requester may be granted every cycle if it is alone.
- Cycle A+1: ROM data available. Stage-2 registers pix_data = hit1 ? HIT_COLOR : mux(fsel1: rom_d0/d1/d2); pix_id=id1; pix_valid=v1.
- Latency: grant pulse to pix_valid = 2 cycles. Fully pipelined, throughput 1 pixel/cycle.
- No req in cycle A: v1=0, rom_addr holds its previous value, pix_valid=0 two cycles later.
- Step change during a request: a step/tick in cycle A+1 does not affect an in-flight pixel, because fsel is latched in A.
- Requester-side rule: requester deasserts req the cycle after its grant, unless it issues a new request. req held high is treated as a new request each cycle.
- Reset mid-operation: in-flight pixels are discarded (no pix_valid after reset); step restarts at 0.
- hit[i] changing after grant has no effect on that pixel.

Decomposition:
- Shared package (anim_pkg):
  - frame select encoding FSEL_F0=2'd0, FSEL_F1=2'd1, FSEL_F2=2'd2;
  - step-to-fsel function;
  - default HIT_COLOR;
  - step width constant STEP_W=4.
- Sub-module rr_arbiter: NREQ-wide round-robin, inputs req/ptr, outputs one-hot grant and encoded index. Reusable for other shared VGA ROMs.

Test Plan:
- Reset, TICK_DIV=4, pause=0 -> step goes 0,1,2,... every 4 clk; after 64 clk step=0 again; rst_n low mid-count forces step=0, pix_valid=0 immediately.
- req=4'b0001, addr0=12'h123, step=5, rom_d1=12'hABC -> grant=0001 at A; rom_addr=12'h123 at A+1; pix_valid=1, pix_id=0, pix_data=12'hABC at A+2.
- req=4'b1111 held continuously, rr_ptr=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; pix_id sequence 0,1,2,3,0 with pix_valid continuous.
- hit[2]=1 with req[2], step=9 -> pix_data=12'h428 regardless of rom_d2; hit dropped after grant, with next request -> rom_d2 value.
- Tick lands the cycle after grant with step 11->12 -> in-flight pixel uses rom_d2; next request uses rom_d0.
- pause=1 for 20 clk with TICK_DIV=4 -> step unchanged; arbitration and pixel returns still occur.

Source files
------------

// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types, constants and frame-select helper for the sprite animation scheduler
package anim_pkg;

  localparam int          STEP_W        = 4;
  localparam logic [11:0] HIT_COLOR_DEF = 12'h428;

  typedef enum logic [1:0] {
    FSEL_F0 = 2'd0,
    FSEL_F1 = 2'd1,
    FSEL_F2 = 2'd2
  } fsel_e;

  // Steps 0-3 and 12-15 both show F0, so the loop returns to its start frame.
  function automatic fsel_e step_to_fsel(input logic [STEP_W-1:0] s);
    if (s < 4'd4 || s >= 4'd12) return FSEL_F0;
    else if (s < 4'd8)          return FSEL_F1;
    else                        return FSEL_F2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr wins
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                       req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                       gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic                               any_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  int pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/sprite_anim_sched.sv
// rtl/sprite_anim_sched.sv - shares the 3-bank sprite frame ROM among pixel requesters, with animation stepping
module sprite_anim_sched
  import anim_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               ADDR_W    = 12,
  parameter int               PIX_W     = 12,
  parameter int               TICK_DIV  = 6000000,
  parameter logic [PIX_W-1:0] HIT_COLOR = PIX_W'(HIT_COLOR_DEF)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     pause,
  input  logic [NREQ-1:0]                          req,
  input  logic [NREQ*ADDR_W-1:0]                   req_addr,
  input  logic [NREQ-1:0]                          hit,
  output logic [NREQ-1:0]                          grant,
  output logic [ADDR_W-1:0]                        rom_addr,
  input  logic [PIX_W-1:0]                         rom_d0,
  input  logic [PIX_W-1:0]                         rom_d1,
  input  logic [PIX_W-1:0]                         rom_d2,
  output logic                                     pix_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] pix_id,
  output logic [PIX_W-1:0]                         pix_data,
  output logic [STEP_W-1:0]                        step
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TCW  = $clog2(TICK_DIV);

  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              v1_q, v1_d;
  logic [ID_W-1:0]   id1_q, id1_d;
  fsel_e             fsel1_q, fsel1_d;
  logic              hit1_q, hit1_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ID_W-1:0]   pix_id_q, pix_id_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              tick;
  logic [ADDR_W-1:0] req_addr_arr [NREQ];
  logic [PIX_W-1:0]  rom_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign tick = (tick_cnt_q == TCW'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_d     = step_q;
    if (!pause) begin
      if (tick) begin
        tick_cnt_d = '0;
        step_d     = step_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Frame select and hit are captured at grant time so a later tick or hit edge cannot alter this pixel.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    v1_d       = arb_any;
    id1_d      = id1_q;
    fsel1_d    = fsel1_q;
    hit1_d     = hit1_q;
    if (arb_any) begin
      rr_ptr_d   = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
      rom_addr_d = req_addr_arr[arb_idx];
      id1_d      = arb_idx;
      fsel1_d    = step_to_fsel(step_q);
      hit1_d     = hit[arb_idx];
    end
  end

  always_comb begin
    case (fsel1_q)
      FSEL_F1: rom_sel = rom_d1;
      FSEL_F2: rom_sel = rom_d2;
      default: rom_sel = rom_d0;
    endcase
    pix_valid_d = v1_q;
    pix_id_d    = v1_q ? id1_q : pix_id_q;
    pix_data_d  = v1_q ? (hit1_q ? HIT_COLOR : rom_sel) : pix_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      step_q      <= '0;
      rr_ptr_q    <= '0;
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
      fsel1_q     <= FSEL_F0;
      hit1_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_id_q    <= '0;
      pix_data_q  <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      step_q      <= step_d;
      rr_ptr_q    <= rr_ptr_d;
      rom_addr_q  <= rom_addr_d;
      v1_q        <= v1_d;
      id1_q       <= id1_d;
      fsel1_q     <= fsel1_d;
      hit1_q      <= hit1_d;
      pix_valid_q <= pix_valid_d;
      pix_id_q    <= pix_id_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign grant     = rst_n ? arb_gnt : '0;
  assign rom_addr  = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_id    = pix_id_q;
  assign pix_data  = pix_data_q;
  assign step      = step_q;

endmodule

// File: tb/tb_sprite_anim_sched.sv
// tb/tb_sprite_anim_sched.sv - scoreboard bench for sprite_anim_sched
module tb_sprite_anim_sched;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int PW   = 12;
  localparam int TD   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pause = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0] hit = '0;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   rom_addr;
  logic [PW-1:0]   rom_d0, rom_d1, rom_d2;
  logic            pix_valid;
  logic [1:0]      pix_id;
  logic [PW-1:0]   pix_data;
  logic [3:0]      step;

  sprite_anim_sched #(
    .NREQ(NREQ), .ADDR_W(AW), .PIX_W(PW), .TICK_DIV(TD), .HIT_COLOR(12'h428)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .req(req), .req_addr(req_addr), .hit(hit),
    .grant(grant), .rom_addr(rom_addr), .rom_d0(rom_d0), .rom_d1(rom_d1), .rom_d2(rom_d2),
    .pix_valid(pix_valid), .pix_id(pix_id), .pix_data(pix_data), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input int bank, input logic [11:0] a);
    case (bank)
      0:       return a ^ 12'hF00;
      1:       return a ^ 12'hB9F;
      default: return a ^ 12'h0F0;
    endcase
  endfunction

  function automatic int bank_of(input int s);
    if (s >= 4 && s <= 7)  return 1;
    if (s >= 8 && s <= 11) return 2;
    return 0;
  endfunction

  always_comb begin
    rom_d0 = rom_word(0, rom_addr);
    rom_d1 = rom_word(1, rom_addr);
    rom_d2 = rom_word(2, rom_addr);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  typedef struct {
    int          id;
    logic [11:0] data;
    int          cyc;
  } item_t;

  item_t       sbq[$];
  int          step_m = 0;
  int          tick_m = 0;
  int          rr_m = 0;
  logic [11:0] rom_addr_m = '0;
  int          cyc = 0;

  always @(negedge clk) begin : mon
    int          g;
    int          j;
    logic [3:0]  eg;
    logic [11:0] a;
    item_t       it;
    cyc++;
    if (!rst_n) begin
      chk("rst_grant", grant, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_step", step, 0);
      chk("rst_rom_addr", rom_addr, 0);
      step_m = 0; tick_m = 0; rr_m = 0; rom_addr_m = '0;
      sbq.delete();
    end else begin
      g = -1; eg = '0;
      for (int k = 0; k < NREQ; k++) begin
        j = (rr_m + k) % NREQ;
        if (g < 0 && req[j]) g = j;
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("step", step, step_m);
      chk("grant", grant, eg);
      chk("rom_addr", rom_addr, rom_addr_m);
      if (pix_valid) begin
        if (sbq.size() == 0) chk("spurious_pix_valid", 1, 0);
        else begin
          it = sbq.pop_front();
          chk("pix_id", pix_id, it.id);
          chk("pix_data", pix_data, it.data);
          chk("pix_latency", cyc - it.cyc, 2);
        end
      end else if (sbq.size() > 0 && cyc - sbq[0].cyc >= 2) begin
        chk("missing_pix_valid", 0, 1);
        sbq.delete(0);
      end
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        it.id   = g;
        it.data = hit[g] ? 12'h428 : rom_word(bank_of(step_m), a);
        it.cyc  = cyc;
        sbq.push_back(it);
        rom_addr_m = a;
        rr_m = (g + 1) % NREQ;
      end
      if (!pause) begin
        if (tick_m == TD - 1) begin
          tick_m = 0;
          step_m = (step_m + 1) % 16;
        end else tick_m++;
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int s, input int t);
    for (int n = 0; n < 300; n++) begin
      tick_clk(1);
      if (step_m == s && (t < 0 || tick_m == t)) return;
    end
    chk("wait_step_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rr [5];
    int         s;
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    tick_clk(3);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_id", pix_id, 0);
    rst_n = 1'b1;

    tick_clk(32);
    chk("step_after_32", step, 8);
    tick_clk(32);
    chk("step_wrap_64", step, 0);

    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_seq", grant, exp_rr[i]);
      tick_clk(1);
    end
    req = '0;
    tick_clk(3);

    wait_step(5, -1);
    req_addr[0 +: AW] = 12'h123;
    req = 4'b0001;
    #1 chk("single_grant", grant, 4'b0001);
    tick_clk(1);
    req = '0;
    chk("single_rom_addr", rom_addr, 12'h123);
    tick_clk(1);
    chk("single_pix_valid", pix_valid, 1);
    chk("single_pix_id", pix_id, 0);
    chk("single_pix_data", pix_data, 12'hABC);

    wait_step(9, -1);
    req_addr[2*AW +: AW] = 12'h456;
    hit = 4'b0100;
    req = 4'b0100;
    tick_clk(1);
    hit = '0;
    tick_clk(1);
    req = '0;
    chk("hit_pix_data", pix_data, 12'h428);
    tick_clk(1);
    chk("nohit_pix_data", pix_data, 12'h4A6);

    wait_step(11, 2);
    req = 4'b0100;
    tick_clk(1);
    req = '0;
    tick_clk(1);
    chk("tick_inflight_data", pix_data, 12'h4A6);
    chk("tick_new_step", step, 12);
    req = 4'b0100;
    tick_clk(1);
    req = '0;
    tick_clk(1);
    chk("tick_next_data", pix_data, 12'hB56);

    pause = 1'b1;
    s = step_m;
    for (int i = 0; i < 20; i++) begin
      req      = 4'($urandom);
      hit      = 4'($urandom);
      req_addr = 48'({$urandom(), $urandom()});
      tick_clk(1);
      chk("pause_step", step, s);
    end
    pause = 1'b0;

    for (int i = 0; i < 200; i++) begin
      req      = 4'($urandom);
      hit      = 4'($urandom);
      req_addr = 48'({$urandom(), $urandom()});
      pause    = ($urandom_range(0, 7) == 0);
      tick_clk(1);
    end
    pause = 1'b0;

    req = 4'b1111;
    tick_clk(2);
    rst_n = 1'b0;
    #1 chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_step", step, 0);
    req = '0;
    tick_clk(2);
    rst_n = 1'b1;
    tick_clk(3);
    for (int i = 0; i < 30; i++) begin
      req      = 4'($urandom);
      req_addr = 48'({$urandom(), $urandom()});
      tick_clk(1);
    end
    req = '0;
    tick_clk(5);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
